ring_arbiter_4: RTL and testbench

RING_ARBITER_4 -- requirements
Module: ring_arbiter_4

---
 rtl/ring_arbiter_4.sv | 141 ++++++++++++++
 tb/tb_ring_arbiter_4.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ring_arbiter_4.sv
// Four-way round-robin arbiter with a one-hot ring token and registered grants.
// Define ARB_TIMEOUT_EN to enable forced release after TIMEOUT grant cycles.
module ring_arbiter_4 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [3:0] token,
  output logic       busy,
  output logic       timeout_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("ring_arbiter_4: TIMEOUT must lie in 2..255");
  end

  state_t     state_q, state_nxt;
  logic [3:0] token_q, token_nxt;
  logic [3:0] gnt_q, gnt_nxt;
  logic [1:0] winner_q, winner_nxt;
  logic [1:0] tok_idx;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic       rel_normal;
  logic       rel_any;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_nxt;
  logic       timeout_q, timeout_nxt;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      token_q   <= 4'b0001;
      gnt_q     <= '0;
      winner_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_nxt;
      token_q   <= token_nxt;
      gnt_q     <= gnt_nxt;
      winner_q  <= winner_nxt;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_nxt;
      timeout_q <= timeout_nxt;
`endif
    end
  end

  // Cyclic scan for the first request at or after the token position
  always_comb begin
    case (token_q)
      4'b0010: tok_idx = 2'd1;
      4'b0100: tok_idx = 2'd2;
      4'b1000: tok_idx = 2'd3;
      default: tok_idx = 2'd0;
    endcase
    pick  = tok_idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = 2'(tok_idx + 2'(i));
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state_q;
    token_nxt   = token_q;
    gnt_nxt     = gnt_q;
    winner_nxt  = winner_q;
    rel_normal  = 1'b0;
    rel_any     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt     = cnt_q;
    timeout_nxt = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_nxt  = GRANT;
          winner_nxt = pick;
          gnt_nxt    = 4'b0001 << pick;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt    = '0;
`endif
        end
      end
      GRANT: begin
        rel_normal = done || !req[winner_q];
        rel_any    = rel_normal;
`ifdef ARB_TIMEOUT_EN
        // A normal release wins over a coincident timeout
        if (!rel_normal) begin
          if (cnt_q == HOLD_LAST) begin
            rel_any     = 1'b1;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_q + 8'd1;
          end
        end
`endif
        if (rel_any) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          token_nxt = 4'b0001 << 2'(winner_q + 2'd1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    gnt   = gnt_q;
    token = token_q;
    busy  = (state_q == GRANT);
`ifdef ARB_TIMEOUT_EN
    timeout_o = timeout_q;
`else
    timeout_o = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ring_arbiter_4.sv
// Directed self-checking bench for ring_arbiter_4 (TIMEOUT = 4).
// Covers ARB_TIMEOUT_EN-dependent behaviour in whichever build it is compiled with.
module tb_ring_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [3:0] token;
  logic       busy;
  logic       timeout_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ring_arbiter_4 #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .token     (token),
    .busy      (busy),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_tok [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    rst  = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    tick();
    chk("rst_gnt",   gnt, 4'b0000);
    chk("rst_token", token, 4'b0001);
    chk("rst_busy",  4'(busy), 4'd0);
    chk("rst_tmo",   4'(timeout_o), 4'd0);
    rst = 1'b1;
    tick();
    chk("idle_noreq_gnt", gnt, 4'b0000);
    chk("idle_noreq_tok", token, 4'b0001);

    // Single request, then done pulse
    req = 4'b0100;
    tick();
    chk("r029_gnt",  gnt, 4'b0100);
    chk("r029_busy", 4'(busy), 4'd1);
    done = 1'b1;
    tick();
    chk("r029_rel_gnt", gnt, 4'b0000);
    chk("r029_rel_tok", token, 4'b1000);
    chk("r029_rel_busy", 4'(busy), 4'd0);
    req = 4'b0000;
    tick();
    chk("done_idle_gnt", gnt, 4'b0000);
    chk("done_idle_tok", token, 4'b1000);
    done = 1'b0;

    // Wrap-around from token 3
    req = 4'b0011;
    tick();
    chk("wrap_gnt", gnt, 4'b0001);
    done = 1'b1;
    tick();
    chk("wrap_rel_gnt", gnt, 4'b0000);
    chk("wrap_rel_tok", token, 4'b0010);
    done = 1'b0;
    req  = 4'b0000;
    tick();

    // Other requesters ignored during grant, then asynchronous reset mid-grant
    req = 4'b0010;
    tick();
    chk("hold_gnt", gnt, 4'b0010);
    req = 4'b1111;
    tick();
    chk("other_req_gnt", gnt, 4'b0010);
    chk("other_req_tok", token, 4'b0010);
    rst = 1'b0;
    #1;
    chk("async_rst_gnt",  gnt, 4'b0000);
    chk("async_rst_tok",  token, 4'b0001);
    chk("async_rst_busy", 4'(busy), 4'd0);
    req = 4'b0000;
    tick();
    rst = 1'b1;

    // Fairness rotation with all requests held
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rot_gnt", gnt, exp_seq[k]);
      chk("rot_busy", 4'(busy), 4'd1);
      done = 1'b1;
      tick();
      chk("rot_idle_gnt", gnt, 4'b0000);
      chk("rot_idle_tok", token, exp_tok[k]);
      done = 1'b0;
    end
    req = 4'b0000;
    tick();

    // Release by dropping the winner's request
    req = 4'b0100;
    tick();
    chk("drop_gnt", gnt, 4'b0100);
    req = 4'b0000;
    tick();
    chk("drop_rel_gnt", gnt, 4'b0000);
    chk("drop_rel_tok", token, 4'b1000);

`ifdef ARB_TIMEOUT_EN
    req = 4'b0001;
    tick();
    chk("tmo_gnt0", gnt, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("tmo_hold_gnt", gnt, 4'b0001);
      chk("tmo_hold_pulse", 4'(timeout_o), 4'd0);
    end
    tick();
    chk("tmo_rel_gnt",   gnt, 4'b0000);
    chk("tmo_rel_pulse", 4'(timeout_o), 4'd1);
    chk("tmo_rel_tok",   token, 4'b0010);
    req = 4'b0000;
    tick();
    chk("tmo_pulse_end", 4'(timeout_o), 4'd0);

    // Normal release on the timeout cycle counts as normal
    req = 4'b0001;
    tick();
    chk("coin_gnt", gnt, 4'b0001);
    tick();
    tick();
    tick();
    chk("coin_hold_gnt", gnt, 4'b0001);
    done = 1'b1;
    tick();
    chk("coin_rel_gnt",   gnt, 4'b0000);
    chk("coin_rel_pulse", 4'(timeout_o), 4'd0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
`else
    req = 4'b0001;
    tick();
    chk("notmo_gnt0", gnt, 4'b0001);
    for (int k = 0; k < 300; k++) begin
      tick();
      chk("notmo_gnt", gnt, 4'b0001);
      chk("notmo_pulse", 4'(timeout_o), 4'd0);
    end
    done = 1'b1;
    tick();
    chk("notmo_rel_gnt", gnt, 4'b0000);
    chk("notmo_rel_tok", token, 4'b0010);
    done = 1'b0;
    req  = 4'b0000;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
